// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement and single-cycle flush.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_nway #(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                if_pc_i,
   input  logic                       if_valid_req_i,
   input  logic                       flush_i,
   output logic                       Icache_ready_o,
   output logic [31:0]                Icache_inst_o,
   output logic                       hit,
   output logic [31:0]                Icache_addr_o,
   output logic                       Icache_valid_req_o,
   input  logic                       mem_ready_i,
   input  logic [LINE_WORDS*32-1:0]   mem_data_i
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]                perf_hit_cnt_o,
   output logic [31:0]                perf_miss_cnt_o
`endif
);

   localparam int unsigned OFF = $clog2(LINE_WORDS * 4);
   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned TW  = 32 - OFF - IDX;
   localparam int unsigned LW  = LINE_WORDS * 32;
   localparam int unsigned PW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

   state_e         state_q, state_d;
   logic [31:0]    pc_q;
   logic [31:0]    word_q;
   logic           hit_q;
   logic           flushed_q;

   logic [SETS-1:0] valid_q [WAYS];
   logic [TW-1:0]   tag_q   [WAYS][SETS];
   logic [LW-1:0]   data_q  [WAYS][SETS];
   logic [PW-1:0]   ptr_q   [SETS];

   logic [IDX-1:0] req_idx, miss_idx;
   logic [TW-1:0]  req_tag, miss_tag;
   int unsigned    req_woff, miss_woff;
   logic           lookup_hit;
   logic [PW-1:0]  hit_way;
   logic [LW-1:0]  hit_line;
   logic [31:0]    hit_word, fill_word;
   logic [PW-1:0]  victim;
   logic           victim_valid;
   logic           install;

   assign req_idx   = if_pc_i[OFF+IDX-1:OFF];
   assign req_tag   = if_pc_i[31:OFF+IDX];
   assign req_woff  = (if_pc_i >> 2) & (LINE_WORDS - 1);
   assign miss_idx  = pc_q[OFF+IDX-1:OFF];
   assign miss_tag  = pc_q[31:OFF+IDX];
   assign miss_woff = (pc_q >> 2) & (LINE_WORDS - 1);

   always_comb begin
      lookup_hit = 1'b0;
      hit_way    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
            lookup_hit = 1'b1;
            hit_way    = PW'(w);
         end
      end
   end

   assign hit_line  = data_q[hit_way][req_idx];
   assign hit_word  = hit_line[32*req_woff +: 32];
   assign fill_word = mem_data_i[32*miss_woff +: 32];

   // Lowest-index invalid way wins; otherwise the round-robin pointer picks the victim.
   always_comb begin
      victim       = ptr_q[miss_idx];
      victim_valid = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][miss_idx]) begin
            victim       = PW'(w);
            victim_valid = 1'b0;
         end
      end
   end

   // A flush seen at any point during the refill keeps the stale line out of the arrays.
   assign install = (state_q == StMiss) && mem_ready_i && !flush_i && !flushed_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (if_valid_req_i) state_d = lookup_hit ? StResp : StMiss;
         StMiss:  if (mem_ready_i) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign Icache_ready_o     = (state_q == StResp);
   assign Icache_inst_o      = Icache_ready_o ? word_q : 32'h0;
   assign hit                = Icache_ready_o & hit_q;
   assign Icache_valid_req_o = (state_q == StMiss);
   assign Icache_addr_o      = Icache_valid_req_o ? {pc_q[31:OFF], {OFF{1'b0}}} : 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         word_q    <= '0;
         hit_q     <= 1'b0;
         flushed_q <= 1'b0;
         for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
         for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && if_valid_req_i) begin
            pc_q      <= if_pc_i;
            hit_q     <= lookup_hit;
            word_q    <= hit_word;
            flushed_q <= 1'b0;
         end
         if (state_q == StMiss) begin
            if (flush_i) flushed_q <= 1'b1;
            if (mem_ready_i) word_q <= fill_word;
         end
         if (flush_i) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
         end else if (install) begin
            valid_q[victim][miss_idx] <= 1'b1;
         end
         if (WAYS > 1 && install && victim_valid) ptr_q[miss_idx] <= ptr_q[miss_idx] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (install) begin
         tag_q[victim][miss_idx]  <= miss_tag;
         data_q[victim][miss_idx] <= mem_data_i;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_hit_cnt_o  <= '0;
         perf_miss_cnt_o <= '0;
      end else if (state_q == StResp) begin
         if (hit_q) perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
         else       perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway (WAYS=2, SETS=16, LINE_WORDS=4) with a fixed-latency ROM model.
module tb_icache_nway;

   localparam int unsigned LWORDS  = 4;
   localparam int          ROM_LAT = 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [31:0]            if_pc_i = '0;
   logic                   if_valid_req_i = 1'b0;
   logic                   flush_i = 1'b0;
   logic                   Icache_ready_o;
   logic [31:0]            Icache_inst_o;
   logic                   hit;
   logic [31:0]            Icache_addr_o;
   logic                   Icache_valid_req_o;
   logic                   mem_ready_i;
   logic [LWORDS*32-1:0]   mem_data_i;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]            perf_hit_cnt_o;
   logic [31:0]            perf_miss_cnt_o;
`endif

   always #5 clk = ~clk;

   icache_nway #(.WAYS(2), .SETS(16), .LINE_WORDS(LWORDS)) dut (
      .clk                (clk),
      .rst                (rst),
      .if_pc_i            (if_pc_i),
      .if_valid_req_i     (if_valid_req_i),
      .flush_i            (flush_i),
      .Icache_ready_o     (Icache_ready_o),
      .Icache_inst_o      (Icache_inst_o),
      .hit                (hit),
      .Icache_addr_o      (Icache_addr_o),
      .Icache_valid_req_o (Icache_valid_req_o),
      .mem_ready_i        (mem_ready_i),
      .mem_data_i         (mem_data_i)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .perf_hit_cnt_o     (perf_hit_cnt_o),
      .perf_miss_cnt_o    (perf_miss_cnt_o)
`endif
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          rom_fills = 0;
   logic [31:0] exp_line = '0;
   logic [31:0] sb_inst [$];
   logic        sb_hit  [$];
   logic [31:0] mon_inst;
   logic        mon_hit;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Line 0x100 holds {0x33,0x22,0x11,0x00}; every other word is derived from its address.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if ((a & ~32'hF) == 32'h100) return ((a >> 2) & 32'h3) * 32'h11;
      return a ^ 32'h5A5A_0000;
   endfunction

   always @(negedge clk) begin
      if (!rst && Icache_ready_o) begin
         if (sb_inst.size() == 0) begin
            check("unexpected_resp", 32'(sb_inst.size()), 32'd1);
         end else begin
            mon_inst = sb_inst.pop_front();
            mon_hit  = sb_hit.pop_front();
            check("inst", Icache_inst_o, mon_inst);
            check("hit", {31'b0, hit}, {31'b0, mon_hit});
         end
      end
   end

   initial begin
      int cnt;
      cnt         = 0;
      mem_ready_i = 1'b0;
      mem_data_i  = '0;
      forever begin
         @(negedge clk);
         if (Icache_valid_req_o && !rst) begin
            cnt++;
            check("rom_addr", Icache_addr_o, exp_line);
            if (cnt == ROM_LAT) begin
               for (int w = 0; w < LWORDS; w++)
                  mem_data_i[w*32 +: 32] = rom_word(Icache_addr_o + 32'(4 * w));
               mem_ready_i = 1'b1;
               rom_fills++;
               @(posedge clk);
               #1 mem_ready_i = 1'b0;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic fetch(input logic [31:0] pc, input logic exp_hit, input int flush_cyc);
      int   cyc;
      int   fills0;
      logic seen;
      @(posedge clk); #1;
      if_pc_i        = pc;
      if_valid_req_i = 1'b1;
      exp_line       = pc & ~32'hF;
      sb_inst.push_back(rom_word(pc));
      sb_hit.push_back(exp_hit);
      fills0 = rom_fills;
      @(posedge clk); #1 if_valid_req_i = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (Icache_ready_o) begin
            seen = 1'b1;
         end else if (cyc == flush_cyc) begin
            flush_i = 1'b1;
            @(posedge clk); #1 flush_i = 1'b0;
         end
      end
      check("latency", 32'(cyc), exp_hit ? 32'd1 : 32'(ROM_LAT + 1));
      check("rom_fills", 32'(rom_fills - fills0), exp_hit ? 32'd0 : 32'd1);
      @(negedge clk);
      check("ready_pulse", {31'b0, Icache_ready_o}, 32'd0);
   endtask

   task automatic flush_pulse();
      @(posedge clk); #1 flush_i = 1'b1;
      @(posedge clk); #1 flush_i = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_ready", {31'b0, Icache_ready_o}, 32'd0);
      check("rst_inst", Icache_inst_o, 32'd0);
      check("rst_hit", {31'b0, hit}, 32'd0);
      check("rst_addr", Icache_addr_o, 32'd0);
      check("rst_valid_req", {31'b0, Icache_valid_req_o}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Cold miss then hit
      fetch(32'h100, 1'b0, 0);
      fetch(32'h104, 1'b1, 0);
`ifdef ICACHE_PERF_CNT_EN
      check("perf_hit", perf_hit_cnt_o, 32'd1);
      check("perf_miss", perf_miss_cnt_o, 32'd1);
`endif

      // Conflict eviction in set 0
      fetch(32'h500, 1'b0, 0);
      fetch(32'h900, 1'b0, 0);
      fetch(32'h508, 1'b1, 0);
      fetch(32'h10C, 1'b0, 0);
      fetch(32'h904, 1'b1, 0);
      fetch(32'h500, 1'b0, 0);

      // Flush invalidates everything
      flush_pulse();
      fetch(32'h104, 1'b0, 0);

      // Flush while in MISS, and on the cycle the refill is accepted
      fetch(32'h200, 1'b0, 1);
      fetch(32'h200, 1'b0, 0);
      fetch(32'h204, 1'b1, 0);
      fetch(32'h308, 1'b0, ROM_LAT);
      fetch(32'h308, 1'b0, 0);
      fetch(32'h30C, 1'b1, 0);

      // Reset mid-miss
      @(posedge clk); #1;
      if_pc_i        = 32'h700;
      if_valid_req_i = 1'b1;
      exp_line       = 32'h700;
      @(posedge clk); #1 if_valid_req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_valid_req", {31'b0, Icache_valid_req_o}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid_req", {31'b0, Icache_valid_req_o}, 32'd0);
      check("mid_rst_addr", Icache_addr_o, 32'd0);
      check("mid_rst_ready", {31'b0, Icache_ready_o}, 32'd0);
      check("mid_rst_inst", Icache_inst_o, 32'd0);
      check("mid_rst_hit", {31'b0, hit}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      fetch(32'h100, 1'b0, 0);
      check("sb_drained", 32'(sb_inst.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
